alu_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared 32-bit ALU datapath in the MIPS core. It accepts operations from two independent masters over valid/ready handshakes, grants the ALU round-robin, registers operands and result, and returns each result with its overflow flag and requester ID on one response port. Only one operation is in flight at a time; the response is held until consumed.

---
 rtl/alu_arbiter.sv | 171 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
//============================================================================
// Module   : alu_arbiter
// Two-requester round-robin front end and sequencer for the shared 32-bit ALU.
// Optional macro ALU_ARB_OVF_STICKY_EN adds per-requester sticky overflow flags.
// Revision : 1.0
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module alu_arbiter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [2:0]   req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [2:0]   req1_op,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [W-1:0] resp_data,
    output logic         resp_ovf,
    output logic         resp_id,
`ifdef ALU_ARB_OVF_STICKY_EN
    output logic [1:0]   ovf_sticky,
    input  logic [1:0]   ovf_clr,
`endif
    output logic         busy
);

    localparam logic [W-1:0] C_ONE = W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           last_grant_q, last_grant_d;
    logic [W-1:0]   opa_q, opb_q;
    logic [2:0]     op_q;
    logic           id_q;
    logic [W-1:0]   res_q, res_d;
    logic           ovf_q, ovf_d;
    logic           w_grant0, w_grant1, w_accept, w_resp_hs;

    // Requester 0 wins unless requester 1 also asks and 0 had the last grant.
    always_comb begin
        w_grant0   = req0_valid & (~req1_valid | last_grant_q);
        w_grant1   = req1_valid & ~w_grant0;
        req0_ready = (state_q == S_IDLE) & w_grant0;
        req1_ready = (state_q == S_IDLE) & w_grant1;
        w_accept   = req0_ready | req1_ready;
        w_resp_hs  = (state_q == S_RESP) & resp_ready;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    state_d      = S_EXEC;
                    last_grant_d = req1_ready;
                end
            end
            S_EXEC:  state_d = S_RESP;
            S_RESP:  if (resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa_q <= '0;
            opb_q <= '0;
            op_q  <= '0;
            id_q  <= 1'b0;
        end else if (w_accept) begin
            opa_q <= req1_ready ? req1_a  : req0_a;
            opb_q <= req1_ready ? req1_b  : req0_b;
            op_q  <= req1_ready ? req1_op : req0_op;
            id_q  <= req1_ready;
        end
    end

    // Overflow is derived from operand and result sign bits only.
    always_comb begin
        res_d = '0;
        ovf_d = 1'b0;
        case (op_q)
            3'd0: res_d = ~opa_q;
            3'd1: res_d = opa_q & opb_q;
            3'd2: res_d = opa_q ^ opb_q;
            3'd3: res_d = opa_q | opb_q;
            3'd4: begin
                res_d = opa_q - C_ONE;
                ovf_d = opa_q[W-1] & ~res_d[W-1];
            end
            3'd5: begin
                res_d = opa_q + opb_q;
                ovf_d = (opa_q[W-1] == opb_q[W-1]) & (res_d[W-1] != opa_q[W-1]);
            end
            3'd6: begin
                res_d = opa_q - opb_q;
                ovf_d = (opa_q[W-1] != opb_q[W-1]) & (res_d[W-1] != opa_q[W-1]);
            end
            default: begin
                res_d = opa_q + C_ONE;
                ovf_d = ~opa_q[W-1] & res_d[W-1];
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '0;
            ovf_q <= 1'b0;
        end else if (state_q == S_EXEC) begin
            res_q <= res_d;
            ovf_q <= ovf_d;
        end
    end

    assign resp_valid = (state_q == S_RESP);
    assign resp_data  = res_q;
    assign resp_ovf   = ovf_q;
    assign resp_id    = id_q;
    assign busy       = (state_q != S_IDLE);

`ifdef ALU_ARB_OVF_STICKY_EN
    logic [1:0] sticky_q, sticky_d, w_set;

    // Set is OR-ed in after the clear so a coincident set wins.
    always_comb begin
        w_set[0] = w_resp_hs & ovf_q & ~id_q;
        w_set[1] = w_resp_hs & ovf_q & id_q;
        sticky_d = (sticky_q & ~ovf_clr) | w_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sticky_q <= 2'b00;
        else     sticky_q <= sticky_d;
    end

    assign ovf_sticky = sticky_q;
`else
    logic w_unused;
    assign w_unused = w_resp_hs;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
//============================================================================
// Module   : tb_alu_arbiter
// Scoreboard bench for alu_arbiter: arbitration, latency, stall, reset, sticky.
// Revision : 1.0
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_alu_arbiter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]   req0_op, req1_op;
    logic         resp_valid, resp_ready, resp_ovf, resp_id, busy;
    logic [W-1:0] resp_data;
`ifdef ALU_ARB_OVF_STICKY_EN
    logic [1:0]   ovf_sticky, ovf_clr;
`endif

    alu_arbiter #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_ovf   (resp_ovf),
        .resp_id    (resp_id),
`ifdef ALU_ARB_OVF_STICKY_EN
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0] d;
        logic         o;
        logic         id;
    } exp_t;

    exp_t sbq[$];
    logic exp_last;

    // Reference: full-precision signed arithmetic, overflow = out of 32-bit range.
    function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [2:0] op);
        exp_t   e;
        longint sa, sb, full;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        full = 0;
        e.id = id;
        e.o  = 1'b0;
        case (op)
            3'd0: e.d = ~a;
            3'd1: e.d = a & b;
            3'd2: e.d = a ^ b;
            3'd3: e.d = a | b;
            default: begin
                case (op)
                    3'd4:    full = sa - 64'sd1;
                    3'd5:    full = sa + sb;
                    3'd6:    full = sa - sb;
                    default: full = sa + 64'sd1;
                endcase
                e.d = full[W-1:0];
                e.o = (full > 64'sd2147483647) || (full < -64'sd2147483648);
            end
        endcase
        return e;
    endfunction

    task automatic wait_resp(output bit ok);
        int n = 0;
        while (resp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = (resp_valid === 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready, resp_valid, resp_ovf, resp_id, busy} !== 6'b0 || resp_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b%b rv=%b data=%h ovf=%b id=%b busy=%b exp all 0",
                     req0_ready, req1_ready, resp_valid, resp_data, resp_ovf, resp_id, busy);
        end
`ifdef ALU_ARB_OVF_STICKY_EN
        checks++;
        if (ovf_sticky !== 2'b00) begin
            errors++;
            $display("FAIL reset_sticky got %b exp 00", ovf_sticky);
        end
`endif
        rst = 1'b0;
        exp_last = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [2:0] op, input string name);
        exp_t e;
        bit   ok;
        int   acc;
        resp_ready = 1'b1;
        if (id) begin
            req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1; req0_valid = 1'b0;
        end else begin
            req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1; req1_valid = 1'b0;
        end
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== (id ? 2'b01 : 2'b10)) begin
            errors++;
            $display("FAIL %s_grant got %b%b exp %b", name, req0_ready, req1_ready, id ? 2'b01 : 2'b10);
        end
        sbq.push_back(model(id, a, b, op));
        exp_last = id;
        acc = cyc + 1;
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 32'hDEAD_BEEF; req1_a = 32'hDEAD_BEEF;
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_exec got rv=%b busy=%b exp rv=0 busy=1", name, resp_valid, busy);
        end
        wait_resp(ok);
        checks++;
        if (!ok || cyc != acc + 1) begin
            errors++;
            $display("FAIL %s_latency got %0d cycles after accept exp 1 (ok=%0b)", name, cyc - acc, ok);
        end
        if (ok) begin
            e = sbq.pop_front();
            checks++;
            if ({resp_data, resp_ovf, resp_id} !== {e.d, e.o, e.id}) begin
                errors++;
                $display("FAIL %s_resp got %h/%b/%b exp %h/%b/%b", name, resp_data, resp_ovf, resp_id,
                         e.d, e.o, e.id);
            end
        end else begin
            sbq.delete();
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle got rv=%b busy=%b exp 0 0", name, resp_valid, busy);
        end
    endtask

    task automatic test_contention();
        exp_t e;
        logic w;
        int   acc_n = 0, resp_n = 0, prev = -1;
        resp_ready = 1'b1;
        req0_op = 3'd7; req1_op = 3'd6;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int c = 0; c < 40 && resp_n < 4; c++) begin
            if (acc_n < 4) begin
                req0_a = (acc_n == 0) ? 32'h7FFF_FFFF : $urandom;
                req1_a = (acc_n == 1) ? 32'h8000_0000 : $urandom;
                req1_b = (acc_n == 1) ? 32'h0000_0001 : $urandom;
            end else begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
            #1;
            if (resp_valid === 1'b1) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL arb_resp got unexpected response id=%b exp none", resp_id);
                end else begin
                    e = sbq.pop_front();
                    if ({resp_data, resp_ovf, resp_id} !== {e.d, e.o, e.id}) begin
                        errors++;
                        $display("FAIL arb_resp got %h/%b/%b exp %h/%b/%b", resp_data, resp_ovf, resp_id,
                                 e.d, e.o, e.id);
                    end
                end
                resp_n++;
            end
            if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
                w = ~exp_last;
                checks++;
                if ({req0_ready, req1_ready} !== (w ? 2'b01 : 2'b10)) begin
                    errors++;
                    $display("FAIL arb_grant got %b%b exp %b", req0_ready, req1_ready, w ? 2'b01 : 2'b10);
                end
                sbq.push_back(w ? model(1'b1, req1_a, req1_b, 3'd6) : model(1'b0, req0_a, req0_b, 3'd7));
                exp_last = w;
                if (prev >= 0) begin
                    checks++;
                    if (cyc + 1 - prev != 3) begin
                        errors++;
                        $display("FAIL arb_spacing got %0d exp 3", cyc + 1 - prev);
                    end
                end
                prev = cyc + 1;
                acc_n++;
            end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++;
        if (acc_n != 4 || resp_n != 4) begin
            errors++;
            $display("FAIL arb_count got acc=%0d resp=%0d exp 4 4", acc_n, resp_n);
        end
        sbq.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_stall();
        exp_t e;
        bit   ok;
        resp_ready = 1'b0;
        req0_a = 32'hA5A5_0F0F; req0_b = 32'hFFFF_0000; req0_op = 3'd2;
        req0_valid = 1'b1; req1_valid = 1'b0;
        #1;
        sbq.push_back(model(1'b0, req0_a, req0_b, req0_op));
        exp_last = 1'b0;
        @(negedge clk);
        req0_valid = 1'b0;
        req1_a = 32'h8000_0000; req1_b = 32'h8000_0000; req1_op = 3'd5; req1_valid = 1'b1;
        wait_resp(ok);
        e = sbq.pop_front();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || {resp_data, resp_ovf, resp_id} !== {e.d, e.o, e.id} ||
                req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d] got rv=%b %h/%b/%b r1rdy=%b exp rv=1 %h/%b/%b r1rdy=0",
                         i, resp_valid, resp_data, resp_ovf, resp_id, req1_ready, e.d, e.o, e.id);
            end
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release got rv=%b r1rdy=%b exp 0 1", resp_valid, req1_ready);
        end
        sbq.push_back(model(1'b1, req1_a, req1_b, req1_op));
        exp_last = 1'b1;
        @(negedge clk);
        req1_valid = 1'b0;
        wait_resp(ok);
        e = sbq.pop_front();
        checks++;
        if (!ok || {resp_data, resp_ovf, resp_id} !== {e.d, e.o, e.id}) begin
            errors++;
            $display("FAIL stall_next got %h/%b/%b exp %h/%b/%b", resp_data, resp_ovf, resp_id, e.d, e.o, e.id);
        end
        @(negedge clk);
    endtask

    task automatic test_rst_exec();
        exp_t e;
        bit   ok;
        resp_ready = 1'b1;
        req0_a = 32'h0000_0001; req0_b = 32'h0000_0002; req0_op = 3'd5;
        req0_valid = 1'b1; req1_valid = 1'b0;
        @(negedge clk);
        req0_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({resp_valid, resp_ovf, resp_id, busy} !== 4'b0 || resp_data !== '0) begin
            errors++;
            $display("FAIL rst_exec_out got rv=%b data=%h ovf=%b id=%b busy=%b exp all 0",
                     resp_valid, resp_data, resp_ovf, resp_id, busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_last = 1'b1;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_resp got rv=%b busy=%b exp 0 0", resp_valid, busy);
        end
        req0_a = 32'h1234_0000; req0_b = 32'h0000_5678; req0_op = 3'd3;
        req1_a = 32'hFFFF_FFFF; req1_op = 3'd0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL rst_first_grant got %b%b exp 10", req0_ready, req1_ready);
        end
        sbq.push_back(model(1'b0, req0_a, req0_b, req0_op));
        exp_last = 1'b0;
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_resp(ok);
        e = sbq.pop_front();
        checks++;
        if (!ok || {resp_data, resp_ovf, resp_id} !== {e.d, e.o, e.id}) begin
            errors++;
            $display("FAIL rst_after_resp got %h/%b/%b exp %h/%b/%b", resp_data, resp_ovf, resp_id,
                     e.d, e.o, e.id);
        end
        @(negedge clk);
    endtask

`ifdef ALU_ARB_OVF_STICKY_EN
    task automatic test_sticky();
        exp_t e;
        bit   ok;
        checks++;
        if (ovf_sticky !== 2'b00) begin
            errors++;
            $display("FAIL sticky_start got %b exp 00", ovf_sticky);
        end
        resp_ready = 1'b1;
        req0_a = 32'h8000_0000; req0_b = 32'h0000_0001; req0_op = 3'd6; req0_valid = 1'b1;
        #1;
        sbq.push_back(model(1'b0, req0_a, req0_b, req0_op));
        @(negedge clk);
        req0_valid = 1'b0;
        wait_resp(ok);
        e = sbq.pop_front();
        checks++;
        if (!ok || {resp_data, resp_ovf, resp_id} !== {e.d, e.o, e.id}) begin
            errors++;
            $display("FAIL sticky_resp got %h/%b/%b exp %h/%b/%b", resp_data, resp_ovf, resp_id, e.d, e.o, e.id);
        end
        @(negedge clk);
        checks++;
        if (ovf_sticky !== 2'b01) begin
            errors++;
            $display("FAIL sticky_set got %b exp 01", ovf_sticky);
        end
        resp_ready = 1'b0;
        req0_a = 32'h7FFF_FFFF; req0_op = 3'd7; req0_valid = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        wait_resp(ok);
        ovf_clr = 2'b01;
        resp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (ovf_sticky !== 2'b01) begin
            errors++;
            $display("FAIL sticky_set_wins got %b exp 01", ovf_sticky);
        end
        @(negedge clk);
        ovf_clr = 2'b00;
        checks++;
        if (ovf_sticky !== 2'b00) begin
            errors++;
            $display("FAIL sticky_clear got %b exp 00", ovf_sticky);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        exp_last = 1'b1;
`ifdef ALU_ARB_OVF_STICKY_EN
        ovf_clr = 2'b00;
`endif
        test_reset();
        test_single(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 3'd5, "r0_add");
        test_single(1'b1, 32'h8000_0000, 32'h0000_0000, 3'd4, "r1_dec");
        test_single(1'b1, 32'hFFFF_0000, 32'h0F0F_0F0F, 3'd1, "r1_and");
        test_contention();
        test_stall();
        test_rst_exec();
`ifdef ALU_ARB_OVF_STICKY_EN
        test_sticky();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
